// File: rtl/scan_matrix_p_pkg.sv
// Shared front-panel parameters package.
// Holds the default scan/debounce parameters, the sequencer state type and
// a helper that sizes index/counter fields for the matrix blocks.
package scan_matrix_p_pkg;

  localparam int unsigned DEF_N_ROWS   = 3;
  localparam int unsigned DEF_N_LAMPS  = 13;
  localparam int unsigned DEF_N_SENSE  = 4;
  localparam int unsigned DEF_DWELL    = 4096;
  localparam int unsigned DEF_BLANK    = 64;
  localparam int unsigned DEF_DEBOUNCE = 4;

  // Debounce counter width; DEBOUNCE is limited to 1..15.
  localparam int unsigned DB_CNT_W = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Width of a field that must hold 0..n-1 (never narrower than 1 bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_matrix_p_debounce.sv
// Per-switch debounce cell.
// Ports:
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   en_i     - one-clock strobe: sample_i is a valid frame sample
//   sample_i - synchronised switch sample, 1 = closed
//   state_o  - debounced level, 1 = closed
//   press_o  - one-clock pulse on an accepted open-to-closed change
module switch_debounce
  import scan_matrix_p_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic sample_i,
  output logic state_o,
  output logic press_o
);

  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                state_q, state_d;
  logic                press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (en_i) begin
      if (sample_i == state_q) begin
        cnt_d = '0;
      end else if (cnt_q + DB_CNT_W'(1) == DB_CNT_W'(DEBOUNCE)) begin
        state_d = ~state_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
    press_d = state_d & ~state_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
    end
  end

  assign state_o = state_q;
  assign press_o = press_q;

endmodule

// File: rtl/scan_matrix_p.sv
// Multiplexed lamp/switch matrix scanner.
// Each row gets BLANK clocks with everything off, then DWELL clocks with its
// strobe and lamp columns driven; switch senses are sampled on the last
// DRIVE clock and debounced per switch across frames.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   lamp_data - lamp image, row r at [r*N_LAMPS +: N_LAMPS], 1 = lit
//   SC        - raw active-low switch senses (asynchronous)
//   LR        - one-hot row strobe during DRIVE
//   LC        - lamp columns of the strobed row
//   sw_state  - debounced switch levels, 1 = closed
//   sw_press  - one-clock press pulses
//   frame     - one-clock pulse when the last row finishes DRIVE
module scan_matrix_p
  import scan_matrix_p_pkg::*;
#(
  parameter int unsigned N_ROWS   = DEF_N_ROWS,
  parameter int unsigned N_LAMPS  = DEF_N_LAMPS,
  parameter int unsigned N_SENSE  = DEF_N_SENSE,
  parameter int unsigned DWELL    = DEF_DWELL,
  parameter int unsigned BLANK    = DEF_BLANK,
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_ROWS*N_LAMPS-1:0]   lamp_data,
  input  logic [N_SENSE-1:0]          SC,
  output logic [N_ROWS-1:0]           LR,
  output logic [N_LAMPS-1:0]          LC,
  output logic [N_ROWS*N_SENSE-1:0]   sw_state,
  output logic [N_ROWS*N_SENSE-1:0]   sw_press,
  output logic                        frame
);

  localparam int unsigned RW = idx_w(N_ROWS);
  localparam int unsigned CW = idx_w(DWELL);

  scan_state_e         state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                last_drive, wrap;
  logic [N_ROWS-1:0]   lr_q, lr_d;
  logic [N_LAMPS-1:0]  lc_q, lc_d;
  logic                frame_q;
  logic [N_SENSE-1:0]  sync1_q, sync2_q;
  logic [N_ROWS-1:0]   row_en;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q + CW'(1);
    last_drive = 1'b0;
    wrap       = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == CW'(BLANK - 1)) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          last_drive = 1'b1;
          state_d    = ST_BLANK;
          cnt_d      = '0;
          if (row_q == RW'(N_ROWS - 1)) begin
            row_d = '0;
            wrap  = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered strobe and
  // columns line up exactly with the state register's BLANK/DRIVE phases.
  always_comb begin
    lr_d   = '0;
    lc_d   = '0;
    row_en = '0;
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      if (state_d == ST_DRIVE && row_d == RW'(r)) begin
        lr_d[r] = 1'b1;
        lc_d    = lamp_data[r*N_LAMPS +: N_LAMPS];
      end
      row_en[r] = last_drive && (row_q == RW'(r));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BLANK;
      row_q   <= '0;
      cnt_q   <= '0;
      lr_q    <= '0;
      lc_q    <= '0;
      frame_q <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
      lc_q    <= lc_d;
      frame_q <= wrap;
      sync1_q <= SC;
      sync2_q <= sync1_q;
    end
  end

  assign LR    = lr_q;
  assign LC    = lc_q;
  assign frame = frame_q;

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar s = 0; s < N_SENSE; s++) begin : g_sense
      switch_debounce #(
        .DEBOUNCE (DEBOUNCE)
      ) u_db (
        .clk_i    (clk),
        .rst_ni   (reset),
        .en_i     (row_en[r]),
        .sample_i (~sync2_q[s]),
        .state_o  (sw_state[r*N_SENSE + s]),
        .press_o  (sw_press[r*N_SENSE + s])
      );
    end
  end

endmodule
